// File: rtl/debounced_input_ctrl_if.sv
// Device-bus control signals between the CPU-side bus master and a debounced-input peripheral.
// Bus data (dbus) is a shared tri-state net and stays a plain inout port on the peripheral.
interface debounced_input_ctrl_if #(
  parameter int unsigned DBITS = 32
);
  logic             wrtEn;
  logic [DBITS-1:0] address;
  logic             intr;

  modport master (output wrtEn, output address, input intr);
  modport slave  (input wrtEn, input address, output intr);
endinterface

// File: rtl/debounced_input_ctrl.sv
// Memory-mapped debounced-input controller: synchronises and debounces a raw input vector,
// queues each committed change in an event FIFO and exposes ready/overrun status plus a level interrupt.
module debounced_input_ctrl #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      IN_BITS         = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 100000,
  parameter int unsigned      FIFO_DEPTH      = 4,
  parameter logic [DBITS-1:0] DATA_ADDR       = 32'hF000_0014,
  parameter logic [DBITS-1:0] EVENT_ADDR      = 32'hF000_0018,
  parameter logic [DBITS-1:0] CTRL_ADDR       = 32'hF000_0114
) (
  input  logic                   clk,
  input  logic                   reset,
  debounced_input_ctrl_if.slave  bus,
  inout  wire  [DBITS-1:0]       dbus,
  input  logic [IN_BITS-1:0]     inputs
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  logic [IN_BITS-1:0] sync1, sync2, cand, deb;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   rdPtr, wrPtr;
  logic [OCC_W-1:0]   occ;
  logic               ready, overrun, ie, intrQ;
  logic [IN_BITS-1:0] fifoMem [FIFO_DEPTH];

  logic [IN_BITS-1:0] candNext, debNext;
  logic [CNT_W-1:0]   cntNext;
  logic [PTR_W-1:0]   rdPtrNext, wrPtrNext, memWrAddr;
  logic [OCC_W-1:0]   occNext;
  logic               readyNext, overrunNext, ieNext;

  logic isData, isEvent, isCtrl;
  logic rdData, rdEvent, wrCtrl, flush;
  logic empty, full, stable, commit, pop, push, overrunSet;
  logic             drive;
  logic [DBITS-1:0] rdWord;
  logic             unusedBits;

  // Bus decode and FIFO handshake terms
  assign isData  = (bus.address == DATA_ADDR);
  assign isEvent = (bus.address == EVENT_ADDR);
  assign isCtrl  = (bus.address == CTRL_ADDR);
  assign rdData  = !bus.wrtEn && isData;
  assign rdEvent = !bus.wrtEn && isEvent;
  assign wrCtrl  = bus.wrtEn && isCtrl;
  assign flush   = wrCtrl && dbus[4];

  assign empty   = (occ == '0);
  assign full    = (occ == OCC_FULL);
  assign stable  = (sync2 == cand);
  assign commit  = stable && (cnt == CNT_LAST) && (cand != deb);
  // A pop frees a slot for a same-edge push; a flush overrides any pop.
  assign pop        = rdEvent && !empty && !flush;
  assign push       = commit && (flush || !full || pop);
  assign overrunSet = commit && (!push || ready);
  assign memWrAddr  = flush ? '0 : wrPtr;

  assign unusedBits = ^{dbus[DBITS-1:9], dbus[7:5], dbus[3], dbus[1:0]};

  // Next-state logic for debounce, FIFO bookkeeping and status bits
  always_comb begin
    candNext    = cand;
    cntNext     = cnt;
    debNext     = deb;
    rdPtrNext   = rdPtr;
    wrPtrNext   = wrPtr;
    occNext     = occ;
    readyNext   = ready;
    overrunNext = overrun;
    ieNext      = ie;

    if (!stable) begin
      candNext = sync2;
      cntNext  = '0;
    end else if (cnt != CNT_LAST) begin
      cntNext = cnt + CNT_W'(1);
    end

    if (commit) begin
      debNext = cand;
    end

    if (flush) begin
      rdPtrNext = '0;
      wrPtrNext = push ? PTR_W'(1) : '0;
      occNext   = push ? OCC_W'(1) : '0;
    end else begin
      if (push) wrPtrNext = wrPtr + PTR_W'(1);
      if (pop)  rdPtrNext = rdPtr + PTR_W'(1);
      if (push && !pop)      occNext = occ + OCC_W'(1);
      else if (pop && !push) occNext = occ - OCC_W'(1);
    end

    // Set by a commit wins over any same-edge clear.
    if (commit)      readyNext = 1'b1;
    else if (rdData) readyNext = 1'b0;

    if (overrunSet)               overrunNext = 1'b1;
    else if (wrCtrl && !dbus[2])  overrunNext = 1'b0;

    if (wrCtrl) ieNext = dbus[8];
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      deb     <= '0;
      cnt     <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      occ     <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
      intrQ   <= 1'b0;
    end else begin
      sync1   <= inputs;
      sync2   <= sync1;
      cand    <= candNext;
      deb     <= debNext;
      cnt     <= cntNext;
      rdPtr   <= rdPtrNext;
      wrPtr   <= wrPtrNext;
      occ     <= occNext;
      ready   <= readyNext;
      overrun <= overrunNext;
      ie      <= ieNext;
      intrQ   <= ieNext & readyNext;
    end
  end

  // Event storage; contents are only meaningful under the occupancy count
  always_ff @(posedge clk) begin
    if (push) fifoMem[memWrAddr] <= cand;
  end

  // Combinational read mux; dbus is released for writes and foreign addresses
  always_comb begin
    drive  = 1'b0;
    rdWord = '0;
    if (!bus.wrtEn) begin
      if (isData) begin
        drive  = 1'b1;
        rdWord = DBITS'(deb);
      end else if (isEvent) begin
        drive = 1'b1;
        if (!empty) begin
          rdWord            = DBITS'(fifoMem[rdPtr]);
          rdWord[DBITS-1]   = 1'b1;
        end
      end else if (isCtrl) begin
        drive         = 1'b1;
        rdWord[0]     = ready;
        rdWord[1]     = !empty;
        rdWord[2]     = overrun;
        rdWord[3]     = full;
        rdWord[8]     = ie;
        rdWord[23:16] = 8'(occ);
      end
    end
  end

  assign dbus     = drive ? rdWord : {DBITS{1'bz}};
  assign bus.intr = intrQ;

endmodule

// File: tb/tb_debounced_input_ctrl.sv
// Randomised self-checking bench for debounced_input_ctrl against a queue-based reference model.
module tb_debounced_input_ctrl;

  localparam int unsigned DBITS   = 32;
  localparam int unsigned IN_BITS = 10;
  localparam int unsigned DEB     = 4;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] DATA_ADDR  = 32'hF000_0014;
  localparam logic [31:0] EVENT_ADDR = 32'hF000_0018;
  localparam logic [31:0] CTRL_ADDR  = 32'hF000_0114;
  localparam logic [31:0] NOWHERE    = 32'hF000_0200;

  logic               clk = 1'b0;
  logic               reset;
  logic [IN_BITS-1:0] inputs;
  wire  [DBITS-1:0]   dbus;
  logic [DBITS-1:0]   tbDrive;
  logic               tbDriveEn;

  assign dbus = tbDriveEn ? tbDrive : {DBITS{1'bz}};
  pullup pu (dbus);

  debounced_input_ctrl_if #(.DBITS(DBITS)) busIf ();

  debounced_input_ctrl #(
    .DBITS(DBITS), .IN_BITS(IN_BITS), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH),
    .DATA_ADDR(DATA_ADDR), .EVENT_ADDR(EVENT_ADDR), .CTRL_ADDR(CTRL_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .bus(busIf), .dbus(dbus), .inputs(inputs)
  );

  always #5 clk = ~clk;

  // Reference model: raw-sample history, debounced value, event queue, status bits
  logic [IN_BITS-1:0] hist[$];
  logic [IN_BITS-1:0] fifoQ[$];
  logic [IN_BITS-1:0] debM;
  logic               readyM, overrunM, ieM;
  logic [31:0]        lastRd;
  int                 vecCount = 0;
  int                 errCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    debM = '0; readyM = 1'b0; overrunM = 1'b0; ieM = 1'b0;
    fifoQ.delete();
    hist.delete();
    repeat (DEB + 2) hist.push_back('0);
  endtask

  function automatic logic [31:0] ctrlWordM();
    logic [31:0] w;
    w      = '0;
    w[0]   = readyM;
    w[1]   = (fifoQ.size() != 0);
    w[2]   = overrunM;
    w[3]   = (fifoQ.size() == DEPTH);
    w[8]   = ieM;
    w[23:16] = 8'(fifoQ.size());
    return w;
  endfunction

  function automatic logic [31:0] expRead(input logic [31:0] addr);
    if (addr == DATA_ADDR)  return 32'(debM);
    if (addr == EVENT_ADDR) return (fifoQ.size() != 0) ? {1'b1, 21'b0, fifoQ[0]} : 32'h0;
    if (addr == CTRL_ADDR)  return ctrlWordM();
    return 32'hFFFF_FFFF;
  endfunction

  // A change commits once the raw value sampled D+1 edges in a row (two edges of sync delay) differs from deb
  task automatic modelEdge(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [IN_BITS-1:0] raw);
    int s;
    logic [IN_BITS-1:0] v;
    logic stableW, commitM, wasReady, wrCtrlM;
    hist.push_back(raw);
    if (hist.size() > 64) void'(hist.pop_front());
    s = hist.size();
    v = hist[s-3];
    stableW = 1'b1;
    for (int j = s - 3 - int'(DEB); j <= s - 3; j++) if (hist[j] != v) stableW = 1'b0;
    commitM  = stableW && (v != debM);
    wrCtrlM  = we && (addr == CTRL_ADDR);
    wasReady = readyM;

    if (wrCtrlM && wdata[4]) fifoQ.delete();
    else if (!we && addr == EVENT_ADDR && fifoQ.size() != 0) void'(fifoQ.pop_front());
    if (wrCtrlM && !wdata[2]) overrunM = 1'b0;
    if (wrCtrlM) ieM = wdata[8];
    if (commitM) begin
      debM = v;
      if (fifoQ.size() < DEPTH) fifoQ.push_back(v);
      else overrunM = 1'b1;
      if (wasReady) overrunM = 1'b1;
      readyM = 1'b1;
    end else if (!we && addr == DATA_ADDR) begin
      readyM = 1'b0;
    end
  endtask

  // One bus cycle: drive at the falling edge, check just after, model the rising edge
  task automatic busCycle(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [IN_BITS-1:0] raw, input string tag);
    busIf.wrtEn   = we;
    busIf.address = addr;
    inputs        = raw;
    tbDriveEn     = we;
    tbDrive       = wdata;
    #1;
    lastRd = dbus;
    checkVal({tag, "_intr"}, 32'(busIf.intr), 32'(readyM & ieM));
    if (we) checkVal({tag, "_wrhiz"}, lastRd, wdata);
    else    checkVal({tag, "_rd"}, lastRd, expRead(addr));
    @(posedge clk);
    modelEdge(we, addr, wdata, raw);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [IN_BITS-1:0] raw, input string tag);
    for (int i = 0; i < n; i++) busCycle(1'b0, NOWHERE, 32'h0, raw, tag);
  endtask

  initial begin
    logic [IN_BITS-1:0] cur, nv;
    logic [31:0] addr, wd;
    logic we;
    int op;
    logic [IN_BITS-1:0] vals [5];

    reset = 1'b0; inputs = '0; busIf.wrtEn = 1'b0; busIf.address = NOWHERE;
    tbDriveEn = 1'b0; tbDrive = '0;
    modelReset();
    repeat (3) @(negedge clk);
    #1 checkVal("rst_intr", 32'(busIf.intr), 32'h0);
    busIf.address = CTRL_ADDR;
    #1 checkVal("rst_ctrl", dbus, 32'h0);
    busIf.address = NOWHERE;
    #1 checkVal("rst_hiz", dbus, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b1;

    // Clean step: commit at the 7th edge
    cur = 10'h2A5;
    idle(6, cur, "step");
    busCycle(1'b0, CTRL_ADDR, 0, cur, "step_pre");
    checkVal("step_not_before_e7", lastRd, 32'h0);
    busCycle(1'b0, CTRL_ADDR, 0, cur, "step_ctrl");
    checkVal("step_ctrl_word", lastRd, 32'h0001_0003);
    busCycle(1'b0, DATA_ADDR, 0, cur, "step_data");
    checkVal("step_data_word", lastRd, 32'h0000_02A5);
    busCycle(1'b0, CTRL_ADDR, 0, cur, "step_ctrl2");
    checkVal("step_ready_clr", lastRd, 32'h0001_0002);

    // Bounce with 3-cycle plateaus, then hold
    busCycle(1'b1, CTRL_ADDR, 32'h10, cur, "bnc_flush");
    for (int i = 0; i <= 20; i++) busCycle(1'b0, NOWHERE, 0, ((i / 3) % 2) ? 10'h2A5 : 10'h2A4, "bnc");
    idle(12, 10'h2A4, "bnc_hold");
    busCycle(1'b0, CTRL_ADDR, 0, 10'h2A4, "bnc_ctrl");
    checkVal("bnc_one_entry", 32'(lastRd[23:16]), 32'd1);
    busCycle(1'b0, EVENT_ADDR, 0, 10'h2A4, "bnc_ev");
    checkVal("bnc_event", lastRd, 32'h8000_02A4);
    busCycle(1'b0, DATA_ADDR, 0, 10'h2A4, "bnc_data");

    // Five changes without reads: full plus overrun
    busCycle(1'b1, CTRL_ADDR, 32'h10, 10'h2A4, "ovr_flush");
    vals = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
    foreach (vals[i]) idle(9, vals[i], "ovr");
    busCycle(1'b0, CTRL_ADDR, 0, 10'h005, "ovr_ctrl");
    checkVal("ovr_ctrl_word", lastRd, 32'h0004_000F);
    for (int i = 0; i < 5; i++) begin
      busCycle(1'b0, EVENT_ADDR, 0, 10'h005, "ovr_ev");
      checkVal("ovr_event", lastRd, (i < 4) ? {1'b1, 21'b0, vals[i]} : 32'h0);
    end
    busCycle(1'b1, CTRL_ADDR, 32'h0, 10'h005, "ovr_clr");
    busCycle(1'b0, CTRL_ADDR, 0, 10'h005, "ovr_ctrl2");
    checkVal("ovr_cleared", lastRd, 32'h0000_0001);

    // Interrupt enable; DATA read on the commit edge keeps ready set
    busCycle(1'b1, CTRL_ADDR, 32'h100, 10'h005, "ie_set");
    busCycle(1'b0, DATA_ADDR, 0, 10'h005, "ie_clr");
    idle(6, 10'h3C3, "ie");
    busCycle(1'b0, DATA_ADDR, 0, 10'h3C3, "ie_race");
    checkVal("ie_race_data", lastRd, 32'h0000_0005);
    busCycle(1'b0, CTRL_ADDR, 0, 10'h3C3, "ie_ctrl");
    checkVal("ie_ready_kept", lastRd, 32'h0001_0103);
    checkVal("ie_intr_high", 32'(busIf.intr), 32'h1);

    // Full FIFO: commit coinciding with pop, then flush coinciding with push
    idle(9, 10'h0F0, "pp"); idle(9, 10'h0F1, "pp"); idle(9, 10'h0F2, "pp");
    busCycle(1'b0, DATA_ADDR, 0, 10'h0F2, "pp_data");
    busCycle(1'b1, CTRL_ADDR, 32'h100, 10'h0F2, "pp_clr");
    idle(6, 10'h155, "pp");
    busCycle(1'b0, EVENT_ADDR, 0, 10'h155, "pp_pop");
    checkVal("pp_pop_head", lastRd, 32'h8000_03C3);
    busCycle(1'b0, CTRL_ADDR, 0, 10'h155, "pp_ctrl");
    checkVal("pp_no_overrun", lastRd, 32'h0004_010B);
    busCycle(1'b0, DATA_ADDR, 0, 10'h2AA, "fl_data");
    idle(5, 10'h2AA, "fl");
    busCycle(1'b1, CTRL_ADDR, 32'h110, 10'h2AA, "fl_flush");
    busCycle(1'b0, CTRL_ADDR, 0, 10'h2AA, "fl_ctrl");
    checkVal("fl_occ_one", lastRd, 32'h0001_0103);
    busCycle(1'b0, EVENT_ADDR, 0, 10'h2AA, "fl_ev");
    checkVal("fl_event", lastRd, 32'h8000_02AA);

    // Randomised traffic
    cur = 10'h2AA;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0)
        cur = $urandom_range(0, 1) ? 10'($urandom) : (cur ^ (10'(1) << $urandom_range(0, 9)));
      op = int'($urandom_range(0, 9));
      we = 1'b0; wd = 32'h0;
      case (op)
        0, 1, 2: addr = NOWHERE;
        3, 4:    addr = DATA_ADDR;
        5, 6:    addr = EVENT_ADDR;
        7:       addr = CTRL_ADDR;
        8:       begin addr = CTRL_ADDR; we = 1'b1; wd = $urandom; end
        default: begin addr = $urandom_range(0, 1) ? DATA_ADDR : EVENT_ADDR; we = 1'b1; wd = $urandom; end
      endcase
      busCycle(we, addr, wd, cur, "rnd");
    end

    // Asynchronous reset mid-debounce with a queued event
    busCycle(1'b1, CTRL_ADDR, 32'h10, cur, "ar_flush");
    nv = debM ^ 10'h155;
    idle(9, nv, "ar_fill");
    idle(3, nv ^ 10'h001, "ar_mid");
    busIf.wrtEn = 1'b0; busIf.address = CTRL_ADDR; tbDriveEn = 1'b0;
    #2 reset = 1'b0;
    #1 checkVal("ar_ctrl", dbus, 32'h0);
    checkVal("ar_intr", 32'(busIf.intr), 32'h0);
    busIf.address = DATA_ADDR;
    #1 checkVal("ar_data", dbus, 32'h0);
    busIf.address = EVENT_ADDR;
    #1 checkVal("ar_event", dbus, 32'h0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    idle(6, 10'h155, "ar_rel");
    busCycle(1'b0, CTRL_ADDR, 0, 10'h155, "ar_pre");
    checkVal("ar_pre_word", lastRd, 32'h0);
    busCycle(1'b0, CTRL_ADDR, 0, 10'h155, "ar_post");
    checkVal("ar_post_word", lastRd, 32'h0001_0003);
    busCycle(1'b0, NOWHERE, 0, 10'h155, "unmapped");
    checkVal("unmapped_hiz", lastRd, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
